// File: rtl/npu_pkg.sv
// Shared drain-stage types and lane-width/saturation helpers; SYSTOLIC_DRAIN_REQUANT_EN selects the requant lane width.
package npu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DONE    = 2'd3
   } drain_state_e;

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
   localparam bit REQUANT_EN = 1'b1;
`else
   localparam bit REQUANT_EN = 1'b0;
`endif

   localparam int DRAIN_ACC_WIDTH = 32;
   localparam int DRAIN_OUT_WIDTH = 8;

   function automatic int lane_w_f(input int acc_w, input int out_w);
      return REQUANT_EN ? out_w : acc_w;
   endfunction

   function automatic longint sat_hi_f(input int out_w);
      return (longint'(1) <<< (out_w - 1)) - 1;
   endfunction

   function automatic longint sat_lo_f(input int out_w);
      return -(longint'(1) <<< (out_w - 1));
   endfunction

   localparam longint DRAIN_SAT_HI = sat_hi_f(DRAIN_OUT_WIDTH);
   localparam longint DRAIN_SAT_LO = sat_lo_f(DRAIN_OUT_WIDTH);

endpackage

// File: rtl/drain_row_fifo.sv
// Synchronous row FIFO with combinational head read; push and pop may share a cycle, including at full.
module drain_row_fifo #(
   parameter  int W     = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [W-1:0]  i_push_dat,
   input  logic          i_pop,
   output logic [W-1:0]  o_head_dat,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_wr_en;
   logic         w_rd_en;

   assign o_count    = r_wr_ptr - r_rd_ptr;
   assign o_empty    = (o_count == '0);
   assign o_full     = (o_count == (AW+1)'(DEPTH));
   // At full a same-cycle pop frees the slot being written, so the push is accepted.
   assign w_wr_en    = i_push && (!o_full || i_pop);
   assign w_rd_en    = i_pop && !o_empty;
   assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/systolic_drain.sv
// Captures aligned core rows, optionally requantizes them (SYSTOLIC_DRAIN_REQUANT_EN) and streams them out of a row FIFO.
// Row-to-out_valid latency is 2 cycles; the core is never stalled, so rows hitting a full FIFO are dropped and flagged.
module systolic_drain
   import npu_pkg::*;
#(
   parameter  int N         = 8,
   parameter  int ACC_WIDTH = DRAIN_ACC_WIDTH,
   parameter  int OUT_WIDTH = DRAIN_OUT_WIDTH,
   parameter  int DEPTH     = 16,
   parameter  int ROW_CNT_W = 16,
   localparam int LANE_W    = lane_w_f(ACC_WIDTH, OUT_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ROW_CNT_W-1:0]   num_rows,
   input  logic [4:0]             shift,
   input  logic                   relu,
   input  logic [N-1:0]           valid_in,
   input  logic [N*ACC_WIDTH-1:0] y_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N*LANE_W-1:0]    out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic                   lane_err
);

   localparam int ROW_W = N * LANE_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   drain_state_e         r_state;
   drain_state_e         w_state_nxt;
   logic [ROW_CNT_W-1:0] r_num_rows;
   logic [ROW_CNT_W-1:0] r_row_cnt;
   logic [ROW_CNT_W-1:0] w_cnt_inc;
   logic                 w_start_acc;
   logic                 w_row_full;
   logic                 w_row_part;
   logic                 w_capture;
   logic                 w_cap_last;
   logic                 r_s1_vld;
   logic                 r_s1_last;
   logic [ROW_W-1:0]     r_s1_dat;
   logic [ROW_W-1:0]     w_s1_dat;
   logic [ROW_W:0]       w_head;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [CNT_W-1:0]     w_fifo_cnt;
   logic                 w_pop;
   logic                 w_drop;
   logic                 r_overflow;
   logic                 r_lane_err;

   assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_row_full  = &valid_in;
   assign w_row_part  = (|valid_in) && !w_row_full;
   assign w_capture   = (r_state == ST_COLLECT) && w_row_full;
   assign w_cnt_inc   = r_row_cnt + 1'b1;
   assign w_cap_last  = w_capture && (w_cnt_inc == r_num_rows);

`ifdef SYSTOLIC_DRAIN_REQUANT_EN
   localparam logic signed [ACC_WIDTH:0] L_SAT_HI = (ACC_WIDTH+1)'(sat_hi_f(OUT_WIDTH));
   localparam logic signed [ACC_WIDTH:0] L_SAT_LO = (ACC_WIDTH+1)'(sat_lo_f(OUT_WIDTH));

   for (genvar j = 0; j < N; j++) begin : g_lane
      logic signed [ACC_WIDTH:0] w_ext;
      logic signed [ACC_WIDTH:0] w_rnd;
      logic signed [ACC_WIDTH:0] w_sum;
      logic signed [ACC_WIDTH:0] w_shr;
      logic signed [ACC_WIDTH:0] w_rel;

      // One guard bit keeps the round-half-up add from wrapping at the positive extreme.
      assign w_ext = {y_in[j*ACC_WIDTH+ACC_WIDTH-1], y_in[j*ACC_WIDTH +: ACC_WIDTH]};
      assign w_rnd = (shift == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift - 5'd1));
      assign w_sum = w_ext + w_rnd;
      assign w_shr = w_sum >>> shift;
      assign w_rel = (relu && w_shr[ACC_WIDTH]) ? '0 : w_shr;
      assign w_s1_dat[j*LANE_W +: LANE_W] = (w_rel > L_SAT_HI) ? L_SAT_HI[LANE_W-1:0] :
                                            (w_rel < L_SAT_LO) ? L_SAT_LO[LANE_W-1:0] :
                                                                 w_rel[LANE_W-1:0];
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{shift, relu};
   assign w_s1_dat     = y_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_dat  <= '0;
      end else begin
         r_s1_vld <= w_capture;
         if (w_capture) begin
            r_s1_dat  <= w_s1_dat;
            r_s1_last <= w_cap_last;
         end
      end
   end

   assign w_pop  = !w_fifo_empty && out_ready;
   assign w_drop = r_s1_vld && w_fifo_full && !w_pop;

   drain_row_fifo #(
      .W     (ROW_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (r_s1_vld),
      .i_push_dat ({r_s1_last, r_s1_dat}),
      .i_pop      (w_pop),
      .o_head_dat (w_head),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_start_acc) begin
               w_state_nxt = (num_rows == '0) ? ST_DONE : ST_COLLECT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (w_cap_last) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Finish only once stage 1 has drained and the FIFO is (or is becoming) empty.
            if (!r_s1_vld && (w_fifo_empty || (w_pop && (w_fifo_cnt == CNT_W'(1))))) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num_rows <= '0;
         r_row_cnt  <= '0;
         r_overflow <= 1'b0;
         r_lane_err <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_num_rows <= num_rows;
            r_row_cnt  <= '0;
            r_overflow <= 1'b0;
            r_lane_err <= 1'b0;
         end else begin
            if (w_capture) begin
               r_row_cnt <= w_cnt_inc;
            end
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
            if ((r_state == ST_COLLECT) && w_row_part) begin
               r_lane_err <= 1'b1;
            end
         end
      end
   end

   assign out_valid = !w_fifo_empty;
   assign out_data  = w_fifo_empty ? '0 : w_head[ROW_W-1:0];
   assign out_last  = !w_fifo_empty && w_head[ROW_W];
   assign busy      = (r_state == ST_COLLECT) || (r_state == ST_FLUSH);
   assign done      = (r_state == ST_DONE);
   assign overflow  = r_overflow;
   assign lane_err  = r_lane_err;

endmodule
